// File: rtl/store_rmw_seq.sv
// store_rmw_seq: store path into the data memory.
// Full doubleword stores (sd) are written directly. Word, half and byte
// stores (sw/sh/sb) read the addressed doubleword, merge the new bytes in,
// and write the merged doubleword back once.
// Optional feature macro: STORE_ALIGN_CHECK_EN. When it is defined,
// misaligned stores are rejected with err and no memory access. When it is
// undefined, offset bits below the access size are ignored.
module store_rmw_seq #(
   parameter int READ_LAT = 1          // data-memory read latency, 1..4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_type,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_data,
   output logic [63:0] mem_addr,
   output logic        mem_re,
   input  logic [63:0] mem_rdata,
   output logic        mem_we,
   output logic [63:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [3:0] TYPE_SD = 4'b0110;
   localparam logic [3:0] TYPE_SW = 4'b0111;
   localparam logic [3:0] TYPE_SH = 4'b1000;
   localparam logic [3:0] TYPE_SB = 4'b1001;
   localparam logic [1:0] LAT_M1  = 2'(READ_LAT - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state_reg;
   logic [1:0]  cnt_reg;
   logic [3:0]  type_reg;
   logic [2:0]  off_reg;
   logic [31:0] data_reg;
   logic [63:0] merged;
   logic        valid_type;
   logic        misaligned;

   assign valid_type = (req_type == TYPE_SD) || (req_type == TYPE_SW) ||
                       (req_type == TYPE_SH) || (req_type == TYPE_SB);

`ifdef STORE_ALIGN_CHECK_EN
   assign misaligned = ((req_type == TYPE_SW) && (req_addr[1:0] != 2'b00)) ||
                       ((req_type == TYPE_SH) && req_addr[0]) ||
                       ((req_type == TYPE_SD) && (req_addr[2:0] != 3'b000));
`else
   assign misaligned = 1'b0;
`endif

   // Per-byte merge: a lane takes store data when the latched offset selects
   // it for the latched access size, otherwise it keeps the read value.
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic       lane_sel;
      logic [7:0] lane_src;
      assign lane_sel = ((type_reg == TYPE_SB) && (off_reg == 3'(gi))) ||
                        ((type_reg == TYPE_SH) && (off_reg[2:1] == 2'(gi / 2))) ||
                        ((type_reg == TYPE_SW) && (off_reg[2] == 1'(gi / 4)));
      assign lane_src = (type_reg == TYPE_SB) ? data_reg[7:0] :
                        (type_reg == TYPE_SH) ? data_reg[8*(gi%2) +: 8] :
                                                data_reg[8*(gi%4) +: 8];
      assign merged[8*gi +: 8] = lane_sel ? lane_src : mem_rdata[8*gi +: 8];
   end

   // Sequencer: state plus all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 2'd0;
         type_reg  <= 4'd0;
         off_reg   <= 3'd0;
         data_reg  <= 32'd0;
         req_ready <= 1'b1;
         mem_addr  <= 64'd0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= 64'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  type_reg  <= req_type;
                  off_reg   <= req_addr[2:0];
                  data_reg  <= req_data[31:0];
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (!valid_type || misaligned) begin
                     done      <= 1'b1;
                     err       <= 1'b1;
                     state_reg <= DONE;
                  end else if (req_type == TYPE_SD) begin
                     mem_addr  <= {req_addr[63:3], 3'b000};
                     mem_we    <= 1'b1;
                     mem_wdata <= req_data;
                     state_reg <= WRITE;
                  end else begin
                     mem_addr  <= {req_addr[63:3], 3'b000};
                     mem_re    <= 1'b1;
                     cnt_reg   <= LAT_M1;
                     state_reg <= READ;
                  end
               end
            end
            READ: begin
               if (cnt_reg == 2'd0) begin
                  mem_wdata <= merged;
                  mem_re    <= 1'b0;
                  mem_we    <= 1'b1;
                  state_reg <= WRITE;
               end else begin
                  cnt_reg <= cnt_reg - 2'd1;
               end
            end
            WRITE: begin
               mem_we    <= 1'b0;
               done      <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               done      <= 1'b0;
               err       <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               mem_addr  <= 64'd0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_rmw_seq.sv
// tb_store_rmw_seq: directed checks of store_rmw_seq with READ_LAT=2.
module tb_store_rmw_seq;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_type = 4'd0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_data = 64'd0;
   logic [63:0] mem_addr;
   logic        mem_re;
   logic [63:0] mem_rdata = 64'd0;
   logic        mem_we;
   logic [63:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int we_cnt    = 0;
   int re_cnt    = 0;

   store_rmw_seq #(.READ_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Count strobe cycles as seen at each rising edge.
   always @(posedge clk) begin
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else
         pass_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Valid store: accept, optional READ phase, WRITE, DONE, back to IDLE.
   task automatic do_store(input string name, input logic [3:0] t, input logic [63:0] a,
                           input logic [63:0] d, input logic [63:0] rd,
                           input logic [63:0] exp_wd, input logic [63:0] exp_a,
                           input bit rmw);
      int we0 = we_cnt;
      int re0 = re_cnt;
      mem_rdata = rd;
      req_valid = 1'b1; req_type = t; req_addr = a; req_data = d;
      step();
      req_valid = 1'b0;
      if (rmw) begin
         for (int i = 1; i <= LAT; i++) begin
            chk({name, "_re"}, 64'(mem_re), 64'd1);
            chk({name, "_we_rd"}, 64'(mem_we), 64'd0);
            chk({name, "_addr_rd"}, mem_addr, exp_a);
            if (i < LAT) step();
         end
         step();
      end
      chk({name, "_we"}, 64'(mem_we), 64'd1);
      chk({name, "_re_wr"}, 64'(mem_re), 64'd0);
      chk({name, "_wdata"}, mem_wdata, exp_wd);
      chk({name, "_addr"}, mem_addr, exp_a);
      chk({name, "_busy"}, 64'(busy), 64'd1);
      step();
      chk({name, "_done"}, 64'(done), 64'd1);
      chk({name, "_err"}, 64'(err), 64'd0);
      chk({name, "_we_off"}, 64'(mem_we), 64'd0);
      step();
      chk({name, "_ready"}, 64'(req_ready), 64'd1);
      chk({name, "_idle_busy"}, 64'(busy), 64'd0);
      chk({name, "_idle_addr"}, mem_addr, 64'd0);
      chk({name, "_done_off"}, 64'(done), 64'd0);
      chk({name, "_we_pulses"}, 64'(we_cnt - we0), 64'd1);
      chk({name, "_re_cycles"}, 64'(re_cnt - re0), rmw ? 64'(LAT) : 64'd0);
      $display("txn %s type=%h addr=%h data=%h wdata=%h", name, t, a, d, mem_wdata);
   endtask

   // Rejected request: done and err at T+1, no memory access.
   task automatic do_reject(input string name, input logic [3:0] t, input logic [63:0] a,
                            input logic [63:0] d);
      int we0 = we_cnt;
      int re0 = re_cnt;
      req_valid = 1'b1; req_type = t; req_addr = a; req_data = d;
      step();
      req_valid = 1'b0;
      chk({name, "_done"}, 64'(done), 64'd1);
      chk({name, "_err"}, 64'(err), 64'd1);
      chk({name, "_re"}, 64'(mem_re), 64'd0);
      chk({name, "_we"}, 64'(mem_we), 64'd0);
      step();
      chk({name, "_done_off"}, 64'(done), 64'd0);
      chk({name, "_err_off"}, 64'(err), 64'd0);
      chk({name, "_ready"}, 64'(req_ready), 64'd1);
      chk({name, "_no_we"}, 64'(we_cnt - we0), 64'd0);
      chk({name, "_no_re"}, 64'(re_cnt - re0), 64'd0);
      $display("txn %s type=%h addr=%h rejected", name, t, a);
   endtask

   initial begin
      int we0;
      // Reset state
      step();
      step();
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_re", 64'(mem_re), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      step();

      do_store("sd", 4'b0110, 64'h100, 64'h1122334455667788, 64'h0,
               64'h1122334455667788, 64'h100, 1'b0);
      do_store("sb", 4'b1001, 64'h203, 64'hAB, 64'hFFFFFFFFFFFFFFFF,
               64'hFFFFFFFFABFFFFFF, 64'h200, 1'b1);
      do_store("sw", 4'b0111, 64'h104, 64'hDEADBEEF, 64'h0,
               64'hDEADBEEF00000000, 64'h100, 1'b1);
      do_store("sh", 4'b1000, 64'h102, 64'h1234, 64'h0,
               64'h0000000012340000, 64'h100, 1'b1);
      do_store("sb7", 4'b1001, 64'h3F, 64'h5A, 64'h0123456789ABCDEF,
               64'h5A23456789ABCDEF, 64'h38, 1'b1);
      do_reject("bad_type", 4'b0010, 64'h100, 64'h55);
`ifdef STORE_ALIGN_CHECK_EN
      do_reject("sw_mis", 4'b0111, 64'h101, 64'h11223344);
`else
      do_store("sw_mis", 4'b0111, 64'h101, 64'h11223344, 64'hFFFFFFFFFFFFFFFF,
               64'hFFFFFFFF11223344, 64'h100, 1'b1);
`endif

      // Reset asserted during the READ phase of an sh
      we0 = we_cnt;
      mem_rdata = 64'h0;
      req_valid = 1'b1; req_type = 4'b1000; req_addr = 64'h306; req_data = 64'hBEEF;
      step();
      req_valid = 1'b0;
      chk("abort_in_read", 64'(mem_re), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_re", 64'(mem_re), 64'd0);
      chk("abort_we", 64'(mem_we), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_ready", 64'(req_ready), 64'd1);
      chk("abort_addr", mem_addr, 64'd0);
      chk("abort_wdata", mem_wdata, 64'd0);
      step();
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("abort_no_we", 64'(we_cnt - we0), 64'd0);
      $display("txn abort sh addr=%h during READ", 64'h306);
      do_store("sd_after", 4'b0110, 64'h408, 64'hCAFEF00D12345678, 64'h0,
               64'hCAFEF00D12345678, 64'h408, 1'b0);

      // Back-to-back sd with req_valid held high
      we0 = we_cnt;
      req_valid = 1'b1; req_type = 4'b0110; req_addr = 64'h500; req_data = 64'hA1A1A1A1A1A1A1A1;
      step();                               // T+1
      req_addr = 64'h508; req_data = 64'hB2B2B2B2B2B2B2B2;
      chk("b2b_we1", 64'(mem_we), 64'd1);
      chk("b2b_wdata1", mem_wdata, 64'hA1A1A1A1A1A1A1A1);
      chk("b2b_addr1", mem_addr, 64'h500);
      step();                               // T+2
      chk("b2b_done1", 64'(done), 64'd1);
      chk("b2b_we_t2", 64'(mem_we), 64'd0);
      step();                               // T+3
      chk("b2b_ready_t3", 64'(req_ready), 64'd1);
      chk("b2b_we_t3", 64'(mem_we), 64'd0);
      step();                               // T+4
      req_valid = 1'b0;
      chk("b2b_we2", 64'(mem_we), 64'd1);
      chk("b2b_wdata2", mem_wdata, 64'hB2B2B2B2B2B2B2B2);
      chk("b2b_addr2", mem_addr, 64'h508);
      step();
      chk("b2b_done2", 64'(done), 64'd1);
      step();
      step();
      chk("b2b_pulses", 64'(we_cnt - we0), 64'd2);
      chk("b2b_idle", 64'(busy), 64'd0);
      $display("txn b2b sd x2 addr=%h,%h", 64'h500, 64'h508);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
